// File: rtl/temp_avg_pkg.sv
// Shared types and constants for the temperature averaging monitor.
package temp_avg_pkg;

    // BCD converter state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } conv_state_t;

    // Active-low segment patterns, bit 6 = g ... bit 0 = a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_F     = 7'b0001110;

    // Ceiling log2, usable in parameter expressions
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// One BCD digit to active-low 7-segment pattern; blank overrides the digit.
module bcd_to_seg7 import temp_avg_pkg::*; (
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Segment lookup; codes above 9 show 'F' so a corrupt digit is visible
    always_comb begin
        seg = SEG_F;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_F;
            endcase
        end
    end

endmodule

// File: rtl/temp_avg_monitor.sv
// Per-channel sample store, running mean, and double-dabble BCD display driver.
//
// state    | meaning
// ST_IDLE  | display stable, waiting for a new average
// ST_SHIFT | shift-add-3 conversion, DATA_W cycles
// ST_LOAD  | copy BCD result to display, restart if an average is pending
module temp_avg_monitor import temp_avg_pkg::*; #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 10,
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          sample,
    input  logic                       sample_vld,
    input  logic [NUM_CH-1:0]          select,
    output logic [NUM_CH*DATA_W-1:0]   ch_val,
    output logic [DATA_W-1:0]          avg,
    output logic                       avg_vld,
    output logic                       err_sel,
    output logic                       busy,
    output logic [7*DIGITS-1:0]        disp_drive
);

    localparam int LG    = clog2(NUM_CH);
    localparam int SUM_W = DATA_W + LG;
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = clog2(DATA_W);

    logic [DATA_W-1:0] ch_q [NUM_CH];
    logic [DATA_W-1:0] ch_d [NUM_CH];
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] avg_q, avg_d;
    logic              avg_vld_q, avg_vld_d;
    logic              err_sel_q, err_sel_d;
    int                num_low;

    conv_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
    logic              pend_q, pend_d;
    logic [BCD_W-1:0]  disp_q, disp_d;
    logic [DIGITS-1:0] blank;
    logic              upper_zero;

    // Select decode, channel write, and sum of the post-write channel values
    always_comb begin
        wr_d    = 1'b0;
        err_d   = 1'b0;
        sum_d   = '0;
        num_low = $countones(~select);
        for (int i = 0; i < NUM_CH; i++) ch_d[i] = ch_q[i];
        if (sample_vld && num_low == 1) begin
            wr_d = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!select[i]) ch_d[i] = sample;
            end
        end else if (sample_vld && num_low > 1) begin
            err_d = 1'b1;
        end
        for (int i = 0; i < NUM_CH; i++) sum_d = sum_d + SUM_W'(ch_d[i]);
    end

    // Average and strobes follow the write by one edge
    always_comb begin
        avg_d     = wr_q ? DATA_W'(sum_q >> LG) : avg_q;
        avg_vld_d = wr_q;
        err_sel_d = err_q;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
            sum_q     <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            avg_q     <= '0;
            avg_vld_q <= 1'b0;
            err_sel_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) ch_q[i] <= ch_d[i];
            sum_q     <= sum_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            avg_q     <= avg_d;
            avg_vld_q <= avg_vld_d;
            err_sel_q <= err_sel_d;
        end
    end

    // Converter next-state; a new average during SHIFT is remembered and taken at LOAD
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        pend_d  = pend_q;
        disp_d  = disp_q;
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        case (state_q)
            ST_IDLE: begin
                if (avg_vld_q) begin
                    state_d = ST_SHIFT;
                    bin_d   = avg_q;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(DATA_W - 1);
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                if (avg_vld_q) pend_d = 1'b1;
                if (cnt_q == '0) state_d = ST_LOAD;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_LOAD: begin
                disp_d = bcd_q;
                if (pend_q || avg_vld_q) begin
                    state_d = ST_SHIFT;
                    bin_d   = avg_q;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(DATA_W - 1);
                    pend_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Converter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            pend_q  <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
        end
    end

    // Leading-zero blanking scans from the top digit down; units never blank
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero && (disp_q[4*i +: 4] == 4'd0);
            blank[i]   = (BLANK_LZ != 0) && upper_zero;
        end
    end

    // Flatten channel registers onto the output bus
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) ch_val[i*DATA_W +: DATA_W] = ch_q[i];
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_to_seg7 u_seg (
            .bcd   (disp_q[4*g +: 4]),
            .blank (blank[g]),
            .seg   (disp_drive[7*g +: 7])
        );
    end

    assign avg     = avg_q;
    assign avg_vld = avg_vld_q;
    assign err_sel = err_sel_q;
    assign busy    = (state_q != ST_IDLE);

endmodule
